// File: rtl/motor_travel_ctrl.sv
// rtl/motor_travel_ctrl.sv - shuttle motor travel controller: home -> end, dwell, end -> home
//
// Ports:
//   CLK        system clock
//   RSTn       asynchronous active-low reset
//   ir         raw async position sensors, ir[0] = home, ir[N_SENS-1] = end
//   sw         raw async start switch, rising edge starts one travel cycle
//   abort      synchronous level abort, forces FAULT from any other state
//   clr_fault  synchronous single-cycle fault clear (ignored while abort high)
//   dir        motor direction, 1 = forward, 0 = backward
//   en         motor enable
//   state      0 IDLE, 1 FWD, 2 DWELL, 3 BWD, 4 FAULT
//   pos        index of the last sensor seen blocked
//   fault      high while in FAULT
//
// Optional feature macro: MOTOR_SEQ_CHECK_EN enables sensor ordering checks.
module motor_travel_ctrl #(
    parameter int N_SENS        = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int IR_ACTIVE_LOW = 1,
    parameter int DWELL_CYC     = 1000,
    parameter int TMO_W         = 24,
    parameter int TMO_CYC       = 10000000
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic [N_SENS-1:0]         ir,
    input  logic                      sw,
    input  logic                      abort,
    input  logic                      clr_fault,
    output logic                      dir,
    output logic                      en,
    output logic [2:0]                state,
    output logic [$clog2(N_SENS)-1:0] pos,
    output logic                      fault
);

    localparam int POS_W = $clog2(N_SENS);
    localparam int DW_W  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FWD   = 3'd1;
    localparam logic [2:0] S_DWELL = 3'd2;
    localparam logic [2:0] S_BWD   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    // Sensors are normalised to "1 = blocked" before synchronising, so every
    // synchroniser flop resets to 0 (unblocked / switch released) and no
    // edge can appear just because reset was released.
    logic [N_SENS-1:0] ir_blk;
    logic [N_SENS:0]   raw_vec;
    assign ir_blk  = (IR_ACTIVE_LOW != 0) ? ~ir : ir;
    assign raw_vec = {sw, ir_blk};

    logic [N_SENS:0] sync_q [SYNC_STAGES];
    logic [N_SENS:0] dly_q;
    logic [N_SENS:0] edge_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            dly_q  <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= raw_vec;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            dly_q  <= sync_q[SYNC_STAGES-1];
            // Registered rise pulse: the FSM acts one edge later.
            edge_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    logic [N_SENS-1:0] blk_edge;
    logic              start_p;
    assign blk_edge = edge_q[N_SENS-1:0];
    assign start_p  = edge_q[N_SENS];

    logic [2:0]       state_q, state_d;
    logic             en_q, en_d, dir_q, dir_d, fault_q, fault_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;

    // Highest and lowest simultaneously blocked sensor.
    logic [POS_W-1:0] hi_idx, lo_idx;
    logic             any_edge;
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        any_edge = |blk_edge;
        for (int k = 0; k < N_SENS; k++)
            if (blk_edge[k]) hi_idx = POS_W'(k);
        for (int k = N_SENS - 1; k >= 0; k--)
            if (blk_edge[k]) lo_idx = POS_W'(k);
    end

    logic seq_err_fwd, seq_err_bwd, start_bad;
`ifdef MOTOR_SEQ_CHECK_EN
    // A sensor may only be re-hit or be the next one in travel direction.
    always_comb begin
        seq_err_fwd = 1'b0;
        seq_err_bwd = 1'b0;
        for (int k = 0; k < N_SENS; k++) begin
            if (blk_edge[k]) begin
                if (k != int'(pos_q) && k != int'(pos_q) + 1) seq_err_fwd = 1'b1;
                if (k != int'(pos_q) && k != int'(pos_q) - 1) seq_err_bwd = 1'b1;
            end
        end
    end
    assign start_bad = (pos_q != '0);
`else
    assign seq_err_fwd = 1'b0;
    assign seq_err_bwd = 1'b0;
    assign start_bad   = 1'b0;
`endif

    logic tmo_hit;
    assign tmo_hit = (tmo_q == TMO_W'(TMO_CYC - 1));

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        fault_d = fault_q;
        tmo_d   = tmo_q;
        dwell_d = dwell_q;
        if (abort && state_q != S_FAULT) begin
            state_d = S_FAULT;
            en_d    = 1'b0;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_d  = 1'b0;
                    dir_d = 1'b1;
                    if (start_p) begin
                        if (start_bad) begin
                            state_d = S_FAULT;
                            fault_d = 1'b1;
                        end else begin
                            state_d = S_FWD;
                            en_d    = 1'b1;
                            tmo_d   = '0;
                        end
                    end
                end
                S_FWD: begin
                    tmo_d = tmo_q + 1'b1;
                    if (any_edge) pos_d = hi_idx;
                    // Reaching the end sensor wins over a same-cycle timeout.
                    if (blk_edge[N_SENS-1]) begin
                        state_d = S_DWELL;
                        en_d    = 1'b0;
                        dwell_d = '0;
                    end else if (seq_err_fwd || tmo_hit) begin
                        state_d = S_FAULT;
                        en_d    = 1'b0;
                        fault_d = 1'b1;
                    end
                end
                S_DWELL: begin
                    if (dwell_q == DW_W'(DWELL_CYC - 1)) begin
                        state_d = S_BWD;
                        en_d    = 1'b1;
                        dir_d   = 1'b0;
                        tmo_d   = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
                S_BWD: begin
                    tmo_d = tmo_q + 1'b1;
                    if (any_edge) pos_d = lo_idx;
                    if (blk_edge[0]) begin
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                        dir_d   = 1'b1;
                    end else if (seq_err_bwd || tmo_hit) begin
                        state_d = S_FAULT;
                        en_d    = 1'b0;
                        fault_d = 1'b1;
                    end
                end
                S_FAULT: begin
                    en_d = 1'b0;
                    if (clr_fault && !abort) begin
                        state_d = S_IDLE;
                        dir_d   = 1'b1;
                        fault_d = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    dir_d   = 1'b1;
                    fault_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            dir_q   <= 1'b1;
            pos_q   <= '0;
            fault_q <= 1'b0;
            tmo_q   <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
            fault_q <= fault_d;
            tmo_q   <= tmo_d;
            dwell_q <= dwell_d;
        end
    end

    assign state = state_q;
    assign en    = en_q;
    assign dir   = dir_q;
    assign pos   = pos_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_motor_travel_ctrl.sv
// tb/tb_motor_travel_ctrl.sv - self-checking bench for motor_travel_ctrl
module tb_motor_travel_ctrl;

    localparam int N     = 3;
    localparam int DWELL = 4;
    localparam int TMO   = 50;
    localparam int LAT   = 4;   // state reacts on the LAT-th edge, sampling edge counted as 1st

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [N-1:0] ir = '1;
    logic       sw = 1'b0, abort = 1'b0, clr_fault = 1'b0;
    logic       dir, en, fault;
    logic [2:0] state;
    logic [1:0] pos;

    logic [3:0] ir4 = '1;
    logic       sw4 = 1'b0;
    logic       dir4, en4, fault4;
    logic [2:0] state4;
    logic [1:0] pos4;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    motor_travel_ctrl #(.N_SENS(N), .SYNC_STAGES(2), .IR_ACTIVE_LOW(1),
                        .DWELL_CYC(DWELL), .TMO_W(24), .TMO_CYC(TMO)) u_dut (
        .CLK(CLK), .RSTn(RSTn), .ir(ir), .sw(sw), .abort(abort), .clr_fault(clr_fault),
        .dir(dir), .en(en), .state(state), .pos(pos), .fault(fault));

    motor_travel_ctrl #(.N_SENS(4), .SYNC_STAGES(2), .IR_ACTIVE_LOW(1),
                        .DWELL_CYC(DWELL), .TMO_W(24), .TMO_CYC(TMO)) u_dut4 (
        .CLK(CLK), .RSTn(RSTn), .ir(ir4), .sw(sw4), .abort(1'b0), .clr_fault(1'b0),
        .dir(dir4), .en(en4), .state(state4), .pos(pos4), .fault(fault4));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Behavioural model: history of sampled inputs, edges seen LAT-1 edges late.
    logic [N-1:0] bh [LAT+1];
    logic         sh [LAT+1];
    int   m_st = 0, m_t = 0, m_d = 0, m_pos = 0;
    logic m_en = 1'b0, m_dir = 1'b1, m_fault = 1'b0;

    always @(posedge CLK or negedge RSTn) begin : model
        logic [N-1:0] e;
        logic         start;
        int           hi, lo;
        if (!RSTn) begin
            for (int i = 0; i <= LAT; i++) begin bh[i] = '0; sh[i] = 1'b0; end
            m_st = 0; m_t = 0; m_d = 0; m_pos = 0;
            m_en = 1'b0; m_dir = 1'b1; m_fault = 1'b0;
        end else begin
            for (int i = LAT; i > 0; i--) begin bh[i] = bh[i-1]; sh[i] = sh[i-1]; end
            bh[0] = ~ir;
            sh[0] = sw;
            e     = bh[LAT-1] & ~bh[LAT];
            start = sh[LAT-1] & ~sh[LAT];
            hi = -1; lo = -1;
            for (int i = 0; i < N; i++) if (e[i]) begin
                hi = i;
                if (lo < 0) lo = i;
            end
            if (abort && m_st != 4) begin
                m_st = 4; m_en = 1'b0; m_fault = 1'b1;
            end else if (m_st == 0) begin
                if (start) begin m_st = 1; m_en = 1'b1; m_dir = 1'b1; m_t = 0; end
            end else if (m_st == 1) begin
                m_t++;
                if (hi >= 0) m_pos = hi;
                if (e[N-1]) begin m_st = 2; m_en = 1'b0; m_d = 0; end
                else if (m_t == TMO) begin m_st = 4; m_en = 1'b0; m_fault = 1'b1; end
            end else if (m_st == 2) begin
                m_d++;
                if (m_d == DWELL) begin m_st = 3; m_en = 1'b1; m_dir = 1'b0; m_t = 0; end
            end else if (m_st == 3) begin
                m_t++;
                if (lo >= 0) m_pos = lo;
                if (e[0]) begin m_st = 0; m_en = 1'b0; m_dir = 1'b1; end
                else if (m_t == TMO) begin m_st = 4; m_en = 1'b0; m_fault = 1'b1; end
            end else begin
                if (clr_fault && !abort) begin m_st = 0; m_dir = 1'b1; m_fault = 1'b0; end
            end
        end
    end

    always @(negedge CLK) begin
        if (RSTn && cmp_en) begin
            chk("cyc_state", int'(state), m_st);
            chk("cyc_en",    int'(en),    int'(m_en));
            chk("cyc_dir",   int'(dir),   int'(m_dir));
            chk("cyc_pos",   int'(pos),   m_pos);
            chk("cyc_fault", int'(fault), int'(m_fault));
        end
    end

    initial begin : stim
        int n;
        tick(3);
        chk("rst_state", int'(state), 0);
        chk("rst_en",    int'(en),    0);
        chk("rst_dir",   int'(dir),   1);
        chk("rst_pos",   int'(pos),   0);
        chk("rst_fault", int'(fault), 0);
        RSTn = 1'b1;
        cmp_en = 1'b1;
        tick(6);
        chk("idle_after_rst", int'(state), 0);

        // Full cycle and sensor latency
        sw = 1'b1;
        tick(LAT - 1);
        chk("start_lat_before", int'(state), 0);
        tick(1);
        chk("start_state", int'(state), 1);
        chk("start_en",    int'(en),    1);
        chk("start_dir",   int'(dir),   1);
        sw = 1'b0;
        tick(2);
        ir[1] = 1'b0;
        tick(LAT);
        chk("mid_pos", int'(pos), 1);
        chk("mid_state", int'(state), 1);
        ir[1] = 1'b1;
        tick(2);
        ir[2] = 1'b0;
        tick(LAT - 1);
        chk("end_lat_before_en", int'(en), 1);
        tick(1);
        chk("end_en",    int'(en),    0);
        chk("end_state", int'(state), 2);
        chk("end_pos",   int'(pos),   2);
        n = 0;
        while (en == 1'b0 && n < 20) begin n++; tick(1); end
        chk("dwell_len", n, 4);
        chk("bwd_state", int'(state), 3);
        chk("bwd_dir",   int'(dir),   0);
        ir[2] = 1'b1;
        ir[0] = 1'b0;
        tick(LAT);
        chk("home_state", int'(state), 0);
        chk("home_en",    int'(en),    0);
        chk("home_dir",   int'(dir),   1);
        chk("home_pos",   int'(pos),   0);
        ir[0] = 1'b1;
        tick(4);

        // Travel timeout
        sw = 1'b1;
        tick(LAT);
        sw = 1'b0;
        chk("tmo_fwd", int'(state), 1);
        n = 0;
        while (state == 3'd1 && n < 200) begin n++; tick(1); end
        chk("tmo_cycles", n, TMO);
        chk("tmo_state",  int'(state), 4);
        chk("tmo_fault",  int'(fault), 1);
        chk("tmo_en",     int'(en),    0);
        clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
        chk("tmo_clr_state", int'(state), 0);
        chk("tmo_clr_fault", int'(fault), 0);
        tick(2);

        // Abort during BWD
        sw = 1'b1; tick(LAT); sw = 1'b0;
        ir[2] = 1'b0; tick(LAT); ir[2] = 1'b1;
        tick(DWELL);
        chk("abt_bwd", int'(state), 3);
        abort = 1'b1; tick(1);
        chk("abt_state", int'(state), 4);
        chk("abt_en",    int'(en),    0);
        chk("abt_dir",   int'(dir),   0);
        clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
        chk("abt_clr_ignored", int'(state), 4);
        abort = 1'b0; tick(1);
        clr_fault = 1'b1; tick(1); clr_fault = 1'b0;
        chk("abt_clr_state", int'(state), 0);
        chk("abt_clr_dir",   int'(dir),   1);
        chk("abt_clr_pos",   int'(pos),   2);
        tick(2);

        // Start requests outside IDLE are dropped
        sw = 1'b1; tick(LAT); sw = 1'b0;
        chk("sw_fwd", int'(state), 1);
        tick(2); sw = 1'b1; tick(5);
        chk("sw_in_fwd", int'(state), 1);
        sw = 1'b0; tick(1);
        ir[2] = 1'b0; tick(LAT);
        chk("sw_dwell", int'(state), 2);
        sw = 1'b1; tick(3);
        chk("sw_in_dwell", int'(state), 2);
        tick(1);
        chk("sw_bwd", int'(state), 3);
        ir[2] = 1'b1; sw = 1'b0;
        ir[0] = 1'b0; tick(LAT);
        chk("sw_home", int'(state), 0);
        tick(4);
        chk("sw_not_queued", int'(state), 0);
        ir[0] = 1'b1; tick(2);
        sw = 1'b1; tick(LAT); sw = 1'b0;
        chk("sw_restart", int'(state), 1);

        // Asynchronous reset mid-travel
        tick(2);
        #3;
        RSTn = 1'b0;
        #1;
        chk("arst_en",    int'(en),    0);
        chk("arst_state", int'(state), 0);
        chk("arst_dir",   int'(dir),   1);
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        tick(6);
        chk("arst_idle", int'(state), 0);

        // Out-of-order sensor on the 4-sensor instance
        sw4 = 1'b1; tick(LAT); sw4 = 1'b0;
        chk("n4_fwd", int'(state4), 1);
        ir4[2] = 1'b0; tick(LAT);
`ifdef MOTOR_SEQ_CHECK_EN
        chk("n4_seq_fault", int'(state4), 4);
        chk("n4_seq_en",    int'(en4),    0);
`else
        chk("n4_skip_state", int'(state4), 1);
        chk("n4_skip_pos",   int'(pos4),   2);
`endif
        ir4[2] = 1'b1;
        tick(2);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
